// File: rtl/seqdet_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// Holds the detector FSM encoding, the power-up pattern/length defaults and
// the helper that decides whether a requested pattern length can be loaded.
package seqdet_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    ARMED = 2'b01,
    HIT   = 2'b10
  } seqdet_state_t;

  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1010;
  localparam int         DEF_LEN     = 5;

  // A pattern length is loadable when it selects at least one bit and no
  // more bits than the history window holds.
  function automatic logic len_valid(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating event counter used for the detector's match count.
// Clear takes priority over increment; the count sticks at all-ones.
module seqdet_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count register: clear wins, otherwise step until saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector with a registered Moore match flag.
// A run-time loaded pattern of 1..MAX_LEN bits is compared against the most
// recent accepted stream bits; overlapping or non-overlapping matching is
// selectable. Build option SEQDET_COUNT_EN adds the saturating match counter;
// without it match_count is tied to zero and cnt_clr is ignored.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int                 MAX_LEN       = DEF_MAX_LEN,
  parameter int                 LEN_W         = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter logic [LEN_W-1:0]   RESET_LEN     = LEN_W'(DEF_LEN),
  parameter logic               RESET_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic               accept;
  logic               cfg_ok;
  logic               hit;
  logic               cfg_err_r;
  seqdet_state_t      state;
  seqdet_state_t      state_next;

  // A configuration write always owns the cycle, so its stream bit is lost.
  assign accept = in_valid & ~cfg_we;
  assign cfg_ok = len_valid(32'(cfg_len), MAX_LEN);

  // Post-shift history, saturating fill level and window compare.
  always_comb begin
    hist_next = hist;
    fill_next = fill;
    if (accept) begin
      hist_next = {hist[MAX_LEN-2:0], x};
      if (fill != FILL_MAX) begin
        fill_next = fill + LEN_W'(1);
      end
    end
    // Bits of the pattern above len are masked out of the compare.
    len_mask = ~({MAX_LEN{1'b1}} << len);
    hit = accept && (fill_next >= len) && (((hist_next ^ pat) & len_mask) == '0);
  end

  // Next-state logic: config load restarts collection; a hit always lands in HIT.
  always_comb begin
    state_next = state;
    if (cfg_we) begin
      if (cfg_ok) begin
        state_next = FILL;
      end else if (state == HIT) begin
        state_next = ovl ? ARMED : FILL;
      end
    end else if (hit) begin
      state_next = HIT;
    end else begin
      case (state)
        FILL:    if (accept && (fill_next >= len)) state_next = ARMED;
        ARMED:   state_next = ARMED;
        HIT:     state_next = ovl ? ARMED : FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // State register; reset abandons any partial match at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Configuration, history and fill registers plus the rejected-config flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RESET_PATTERN;
      len       <= RESET_LEN;
      ovl       <= RESET_OVERLAP;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we & ~cfg_ok;
      if (cfg_we) begin
        if (cfg_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end
      end else begin
        hist <= hist_next;
        // Non-overlap: the next occurrence must be built from fresh bits.
        fill <= (hit && !ovl) ? '0 : fill_next;
      end
    end
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    match   = (state == HIT);
    cfg_err = cfg_err_r;
  end

`ifdef SEQDET_COUNT_EN
  logic cnt_inc;
  assign cnt_inc = (state_next == HIT);

  seqdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (match_count)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: vector table with expected flags per
// cycle, a scoreboard queue for expected outputs, and hand-written reset cases.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               x = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               match;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .x           (x),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             we;
    logic [7:0]       pat;
    logic [3:0]       len;
    logic             ovl;
    logic             vld;
    logic             xb;
    logic             clr;
    logic             em;
    logic             ee;
  } vec_t;

  typedef struct packed {
    logic             em;
    logic             ee;
    logic [CNT_W-1:0] ecnt;
  } exp_t;

  vec_t             vecs[$];
  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] cnt_model = '0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic void add_bit(input logic b, input logic em);
    vecs.push_back('{we:1'b0, pat:8'h00, len:4'd0, ovl:1'b0, vld:1'b1, xb:b, clr:1'b0, em:em, ee:1'b0});
  endfunction

  function automatic void add_idle(input logic clr);
    vecs.push_back('{we:1'b0, pat:8'h00, len:4'd0, ovl:1'b0, vld:1'b0, xb:1'b0, clr:clr, em:1'b0, ee:1'b0});
  endfunction

  function automatic void add_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                                  input logic vld, input logic b, input logic ee);
    vecs.push_back('{we:1'b1, pat:p, len:l, ovl:o, vld:vld, xb:b, clr:1'b0, em:1'b0, ee:ee});
  endfunction

  // bits[n-1] is sent first; em uses the same ordering
  function automatic void add_stream(input logic [15:0] bits, input int n, input logic [15:0] em);
    for (int i = n - 1; i >= 0; i--) add_bit(bits[i], em[i]);
  endfunction

  task automatic apply(input vec_t v, input string name, input int idx);
    exp_t e;
    @(negedge clk);
    cfg_we      = v.we;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    in_valid    = v.vld;
    x           = v.xb;
    cnt_clr     = v.clr;
`ifdef SEQDET_COUNT_EN
    if (v.clr) cnt_model = '0;
    else if (v.em && (cnt_model != '1)) cnt_model = cnt_model + CNT_W'(1);
`else
    cnt_model = '0;
`endif
    sb.push_back('{em:v.em, ee:v.ee, ecnt:cnt_model});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, idx, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_match"}, idx, int'(match), int'(e.em));
      check({name, "_cfg_err"}, idx, int'(cfg_err), int'(e.ee));
      check({name, "_count"}, idx, int'(match_count), int'(e.ecnt));
    end
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], name, i);
    vecs.delete();
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0; x = 1'b0; cnt_clr = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    cnt_model = '0;
    #1;
    check({name, "_match"}, 0, int'(match), 0);
    check({name, "_cfg_err"}, 0, int'(cfg_err), 0);
    check({name, "_count"}, 0, int'(match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_match", 0, int'(match), 0);
    check("reset_cfg_err", 0, int'(cfg_err), 0);
    check("reset_count", 0, int'(match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern 01010, len 5, overlap: matches after bits 5 and 7
    add_stream(16'b0101010, 7, 16'b0000101);
    add_idle(1'b0);
    run_vecs("dflt_ovl");

    // Non-overlap: single match, then counter clear
    add_cfg(8'h0A, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    add_stream(16'b0101010, 7, 16'b0000100);
    add_idle(1'b1);
    run_vecs("non_ovl");

    // Gapped input: three idle cycles after every valid bit
    add_cfg(8'h0A, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      add_bit(((5'b01010 >> i) & 5'd1) != 5'd0, i == 0);
      add_idle(1'b0);
      add_idle(1'b0);
      add_idle(1'b0);
    end
    run_vecs("gapped");

    // Maximum length, then near miss, then partial window that must not match
    add_cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(16'b1010_0101, 8, 16'b0000_0001);
    add_cfg(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(16'b1010_0100, 8, 16'b0000_0000);
    add_cfg(8'h05, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(16'b101, 3, 16'b000);
    run_vecs("max_len");

    // Rejected configs (len 0 and len 9) leave the old pattern working
    add_cfg(8'h0A, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    add_cfg(8'hFF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    add_stream(16'b0101, 4, 16'b0000);
    add_cfg(8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    add_bit(1'b0, 1'b1);
    add_idle(1'b0);
    run_vecs("cfg_err");

    // Config with a valid bit in the same cycle: that bit is discarded
    add_cfg(8'h03, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    add_stream(16'b1110, 4, 16'b0110);
    run_vecs("cfg_drop");

    // Counter saturation and clear coincident with a match
    add_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(16'b1111, 4, 16'b1111);
    vecs.push_back('{we:1'b0, pat:8'h00, len:4'd0, ovl:1'b0, vld:1'b1, xb:1'b1, clr:1'b1, em:1'b1, ee:1'b0});
    add_stream(16'b10, 2, 16'b10);
    run_vecs("counter");

    // Asynchronous reset while match is high
    add_cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_bit(1'b1, 1'b1);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "pre_async", i);
    vecs.delete();
    cfg_we = 1'b0; in_valid = 1'b0; x = 1'b0;
    async_reset("async_hit");

    // Reset restores default pattern and drops partial 0101
    add_stream(16'b0101, 4, 16'b0000);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "pre_rst", i);
    vecs.delete();
    in_valid = 1'b0; x = 1'b0;
    async_reset("mid_rst");
    add_bit(1'b0, 1'b0);
    add_stream(16'b01010, 5, 16'b00001);
    run_vecs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
